// File: rtl/rv32i_pkg.sv
// Shared rv32i encodings and the issue-unit state type.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_ILL  = 2'd3
    } issue_state_e;

    // True for the OP / OP-IMM encodings this unit executes.
    function automatic logic is_legal_alu(input logic [31:0] instr);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       legal;
        opc   = instr[6:0];
        f3    = instr[14:12];
        f7    = instr[31:25];
        legal = 1'b0;
        if (opc == OPC_OP) begin
            legal = (f7 == FUNCT7_BASE) ||
                    ((f7 == FUNCT7_ALT) && ((f3 == ALU_ADD) || (f3 == ALU_SRL)));
        end else if (opc == OPC_OP_IMM) begin
            if (f3 == ALU_SLL) begin
                legal = (f7 == FUNCT7_BASE);
            end else if (f3 == ALU_SRL) begin
                legal = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
            end else begin
                legal = 1'b1;
            end
        end
        return legal;
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32 x 32-bit integer register file: two operand read ports and a debug
// read port, all combinational, one synchronous write port. x0 reads 0.
module regfile_32x32 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    output logic [31:0] o_rdata_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_b,
    input  logic [4:0]  i_dbg_addr,
    output logic [31:0] o_dbg_data
);

    logic [31:0] r_mem [32];

    // Register storage: cleared on reset, x0 never written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == 5'd0) ? 32'd0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == 5'd0) ? 32'd0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? 32'd0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// rv32i OP / OP-IMM issue unit: decodes one instruction at a time, drives
// registered operands into an external ALU, then writes the result back.
//
// state   | meaning
// IDLE    | ready for the next instruction
// EXEC    | operands held at the ALU, waiting ALU_LATENCY cycles
// WB      | writeback strobe, register file written at end of cycle
// ILL     | one-cycle illegal-instruction pulse
module alu_issue_unit
    import rv32i_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_instr_valid,
    input  logic [31:0] i_instr,
    output logic        o_instr_ready,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [2:0]  o_alu_opcode,
    output logic        o_alu_alt,
    input  logic [31:0] i_alu_result,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_illegal,
    input  logic [4:0]  i_dbg_addr,
    output logic [31:0] o_dbg_data
);

    localparam int               CNT_W    = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY);

    issue_state_e     r_state;
    issue_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic        r_alu_alt;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_legal;
    logic        w_alu_done;
    logic        w_wb_fire;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_op_b;
    logic        w_alt;

    assign o_instr_ready = (r_state == ST_IDLE) && !i_rst;
    assign w_accept      = i_instr_valid && o_instr_ready;
    assign w_alu_done    = (r_state == ST_EXEC) && (r_cnt == CNT_LAST);
    assign w_wb_fire     = (r_state == ST_WB) && !i_rst;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_rs1 = i_instr[19:15];
    assign w_rs2 = i_instr[24:20];
    assign w_rd  = i_instr[11:7];

    assign w_legal = is_legal_alu(i_instr);

    regfile_32x32 u_regfile (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (w_wb_fire),
        .i_waddr    (r_wb_rd),
        .i_wdata    (r_wb_data),
        .i_raddr_a  (w_rs1),
        .o_rdata_a  (w_rs1_data),
        .i_raddr_b  (w_rs2),
        .o_rdata_b  (w_rs2_data),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    // Operand B and alternate-op select for the incoming instruction.
    always_comb begin
        w_op_b = {{20{i_instr[31]}}, i_instr[31:20]};
        w_alt  = 1'b0;
        if (w_opc == OPC_OP) begin
            w_op_b = w_rs2_data;
            w_alt  = i_instr[30];
        end else if ((w_f3 == ALU_SLL) || (w_f3 == ALU_SRL)) begin
            w_op_b = {27'd0, i_instr[24:20]};
            w_alt  = (w_f3 == ALU_SRL) ? i_instr[30] : 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_legal ? ST_EXEC : ST_ILL;
                end
            end
            ST_EXEC: begin
                if (w_alu_done) begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_WB:   w_state_nxt = ST_IDLE;
            ST_ILL:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and ALU latency counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == ST_EXEC) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Operand latch at accept and result capture at the end of EXEC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alu_a   <= 32'd0;
            r_alu_b   <= 32'd0;
            r_alu_op  <= 3'd0;
            r_alu_alt <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
        end else begin
            if (w_accept && w_legal) begin
                r_alu_a   <= w_rs1_data;
                r_alu_b   <= w_op_b;
                r_alu_op  <= w_f3;
                r_alu_alt <= w_alt;
                r_wb_rd   <= w_rd;
            end
            if (w_alu_done) begin
                r_wb_data <= i_alu_result;
            end
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_opcode = r_alu_op;
    assign o_alu_alt    = r_alu_alt;
    assign o_wb_valid   = w_wb_fire;
    assign o_wb_rd      = r_wb_rd;
    assign o_wb_data    = r_wb_data;
    assign o_illegal    = (r_state == ST_ILL) && !i_rst;

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Front end of the rv32i integer datapath; the producer side of the ALU operand/opcode interface. Accepts one OP or OP-IMM instruction per handshake and decodes it. Reads the 32-entry register file, drives registered operands, opcode and alternate-op select into the ALU, then captures the ALU result and writes it back. Instructions are strictly serialized, so no hazard logic is needed.

## Interface
Parameters:
- ALU_LATENCY, 1: cycles from operands stable at ALU inputs to a valid `i_alu_result` (0 = combinational ALU).

Ports:
- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_instr_valid  in  1  instruction present
- i_instr  in  32  rv32i instruction word
- o_instr_ready  out  1  unit can accept an instruction
- o_alu_a  out  32  operand A (rs1 value)
- o_alu_b  out  32  operand B (rs2 value, sign-extended imm, or zero-extended shamt)
- o_alu_opcode  out  3  funct3
- o_alu_alt  out  1  SUB/SRA select
- i_alu_result  in  32  ALU result
- o_wb_valid  out  1  one-cycle writeback strobe
- o_wb_rd  out  5  destination register
- o_wb_data  out  32  writeback data
- o_illegal  out  1  one-cycle illegal-instruction pulse
- i_dbg_addr  in  5  debug register-file read address
- o_dbg_data  out  32  combinational register-file read; x0 reads 0

## Operation
- States: IDLE, EXEC, WB, ILL.
- `o_instr_ready` = (state == IDLE) && !i_rst.
- Accept: i_instr_valid && o_instr_ready.
- On accept, decode the instruction:
  - Legal OP (0110011): funct7 == 0000000, or funct7 == 0100000 with funct3 ∈ {000, 101}.
  - Legal OP-IMM (0010011): any funct3 except the following restrictions.
    - funct3 001 requires funct7 == 0000000.
    - funct3 101 requires funct7 ∈ {0000000, 0100000}.
  - Any other opcode or funct7 is illegal.
- Legal instruction, at the accept edge: latch rd and funct3, and latch the operands.
  - o_alu_a = RF[rs1].
  - o_alu_b:
    - OP: RF[rs2].
    - OP-IMM shifts: {27'b0, shamt}.
    - Other OP-IMM: sign-extended imm[11:0].
  - o_alu_alt = instr[30] for OP, and for OP-IMM with funct3 101; otherwise 0. Never 1 for ADDI.
  - Next state EXEC; cycle counter cleared to 0.
- Illegal instruction: next state ILL. No operand or rd update.
- EXEC: counter increments each cycle. When counter == ALU_LATENCY:
  - capture i_alu_result into the WB data register;
  - next state WB.
- WB: o_wb_valid = 1 and the register file is written at the end of the cycle. Next state IDLE.
- ILL: o_illegal = 1. Next state IDLE.
- Register file:
  - x0 is hardwired to 0; writes with rd == 0 still pulse o_wb_valid but do not change RF.
  - Operand reads happen only at accept.
- Operand, opcode and alt outputs hold their value from EXEC entry until the next accept.

## Timing
- Reset (synchronous, edge with i_rst = 1):
  - state IDLE;
  - all RF entries 0;
  - o_alu_a, o_alu_b, o_alu_opcode, o_alu_alt, o_wb_rd, o_wb_data = 0;
  - o_wb_valid, o_illegal, o_instr_ready = 0 while i_rst is high.
- Accept in cycle T:
  - EXEC spans T+1 .. T+1+ALU_LATENCY.
  - WB in cycle T+2+ALU_LATENCY.
  - Ready again in T+3+ALU_LATENCY.
  - Throughput is one instruction per ALU_LATENCY+3 cycles.
- An instruction accepted in the cycle after WB reads the value just written.
- Illegal accept in T: o_illegal high in T+1 only; ready again in T+2.
- Reset asserted mid-EXEC or mid-WB abandons the instruction. No writeback occurs in the reset cycle or after it.
- i_instr may change freely when not accepted; it is sampled only at accept.

## Structure
- Shared package `rv32i_pkg`:
  - OPC_OP = 7'b0110011, OPC_OP_IMM = 7'b0010011;
  - funct3 constants ALU_ADD … ALU_AND (000–111);
  - FUNCT7_ALT = 7'b0100000;
  - the issue-state enum.
- One sub-module: `regfile_32x32`.
  - Two synchronous-use read ports plus the debug read port, all combinational.
  - One write port; x0 forced to 0; synchronous reset clear.
- Decode, FSM and latency counter live in the top level.

## Test plan
Bench uses a behavioural ALU model with ALU_LATENCY = 1.
- Reset, then 0x00500093 (addi x1,x0,5).
  - Required: o_alu_a = 0, o_alu_b = 5, opcode 000, alt 0.
  - Required: o_wb_valid in T+3 with rd = 1, data = 5; dbg x1 = 5.
- 0x00108133 (add x2,x1,x1), then 0x401101B3 (sub x3,x2,x1).
  - Required: x2 = 10.
  - Required: the sub issues a = 10, b = 5, alt 1; x3 = 5.
- 0xFFF00293 (addi x5,x0,-1), then 0x40115213 (srai x4,x2,1).
  - Required: the addi issues o_alu_b = 0xFFFFFFFF.
  - Required: the srai issues o_alu_b = 1, opcode 101, alt 1; x4 = 5.
- 0x00700013 (addi x0,x0,7).
  - Required: o_wb_valid pulses with rd = 0; dbg x0 stays 0.
- 0x0000006F (jal) accepted in T.
  - Required: o_illegal high in T+1 only; no o_wb_valid; ready in T+2; RF unchanged.
- Accept addi x6,x0,9, then assert i_rst in its first EXEC cycle.
  - Required: no o_wb_valid; dbg x6 = 0.
  - Required: ready returns the cycle after reset deasserts.
